// File: rtl/display_pkg.sv
// Shared constants for the BCD display path: segment bit layout, 7-seg codes
// and the serializer FSM state encoding.
package display_pkg;
   localparam int SEG_W = 8;
   localparam int BCD_W = 4;

   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   localparam logic [SEG_W-1:0] SEG_CODE_0 = 8'h3F;
   localparam logic [SEG_W-1:0] SEG_CODE_1 = 8'h06;
   localparam logic [SEG_W-1:0] SEG_CODE_2 = 8'h5B;
   localparam logic [SEG_W-1:0] SEG_CODE_3 = 8'h4F;
   localparam logic [SEG_W-1:0] SEG_CODE_4 = 8'h66;
   localparam logic [SEG_W-1:0] SEG_CODE_5 = 8'h6D;
   localparam logic [SEG_W-1:0] SEG_CODE_6 = 8'h7D;
   localparam logic [SEG_W-1:0] SEG_CODE_7 = 8'h07;
   localparam logic [SEG_W-1:0] SEG_CODE_8 = 8'h7F;
   localparam logic [SEG_W-1:0] SEG_CODE_9 = 8'h6F;
   localparam logic [SEG_W-1:0] SEG_OFF    = 8'h00;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_LATCH
   } ser_state_t;
endpackage

// File: rtl/bcd_seg_encoder.sv
// One digit: BCD to segment byte with decimal point, forced blank and output polarity.
module bcd_seg_encoder
   import display_pkg::*;
#(
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic [BCD_W-1:0] bcd,
   input  logic             dp,
   input  logic             blank,
   output logic [SEG_W-1:0] seg_byte
);

   logic [SEG_W-1:0] lit;

   always_comb begin
      unique case (bcd)
         4'd0:    lit = SEG_CODE_0;
         4'd1:    lit = SEG_CODE_1;
         4'd2:    lit = SEG_CODE_2;
         4'd3:    lit = SEG_CODE_3;
         4'd4:    lit = SEG_CODE_4;
         4'd5:    lit = SEG_CODE_5;
         4'd6:    lit = SEG_CODE_6;
         4'd7:    lit = SEG_CODE_7;
         4'd8:    lit = SEG_CODE_8;
         4'd9:    lit = SEG_CODE_9;
         default: lit = SEG_OFF;
      endcase
      lit[SEG_DP] = dp;
      // Blank mask kills the dp as well, so it is applied last.
      if (blank) lit = SEG_OFF;
      seg_byte = ACTIVE_LOW ? ~lit : lit;
   end

endmodule

// File: rtl/bcd_display_serializer.sv
// Snapshots a frame of BCD digits, encodes to segment bytes and shifts them out
// MSB-first to a chained external shift register, followed by a latch pulse.
module bcd_display_serializer
   import display_pkg::*;
#(
   parameter int NUM_DIGITS     = 6,
   parameter int CLK_DIV        = 2,
   parameter bit ACTIVE_LOW_SEG = 1'b0
) (
   input  logic                        i_clk,
   input  logic                        i_reset_n,
   input  logic                        i_en,
   input  logic                        i_start,
   input  logic [BCD_W*NUM_DIGITS-1:0] i_bcd,
   input  logic [NUM_DIGITS-1:0]       i_blank_mask,
   input  logic [NUM_DIGITS-1:0]       i_dp_mask,
   input  logic                        i_lzb_en,
   output logic                        o_busy,
   output logic                        o_done,
   output logic                        o_sclk,
   output logic                        o_sdata,
   output logic                        o_latch
);

   localparam int NBITS = SEG_W * NUM_DIGITS;
   localparam int BIT_W = $clog2(NBITS);
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [NUM_DIGITS-1:0] lzb_blank;
   logic                  zero_run;
   logic [NBITS-1:0]      enc_frame;
   logic [NBITS-1:0]      frame;
   logic [BIT_W-1:0]      bit_cnt;
   logic [DIV_W-1:0]      div_cnt;
   ser_state_t            state;

   // Zero run from the top digit down; digit 0 always stays visible.
   always_comb begin
      lzb_blank = '0;
      zero_run  = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         zero_run     = zero_run & (i_bcd[k*BCD_W +: BCD_W] == '0);
         lzb_blank[k] = i_lzb_en & zero_run & (k != 0);
      end
   end

   // An LZB-blanked digit is fed as an off code so its dp still follows the mask.
   for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_enc
      bcd_seg_encoder #(
         .ACTIVE_LOW (ACTIVE_LOW_SEG)
      ) u_enc (
         .bcd      (lzb_blank[k] ? 4'hF : i_bcd[k*BCD_W +: BCD_W]),
         .dp       (i_dp_mask[k]),
         .blank    (i_blank_mask[k]),
         .seg_byte (enc_frame[k*SEG_W +: SEG_W])
      );
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n || !i_en) begin
         state   <= ST_IDLE;
         frame   <= '0;
         bit_cnt <= '0;
         div_cnt <= '0;
         o_busy  <= 1'b0;
         o_done  <= 1'b0;
         o_sclk  <= 1'b0;
         o_sdata <= 1'b0;
         o_latch <= 1'b0;
      end else begin
         o_done <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (i_start) begin
                  frame   <= enc_frame << 1;
                  o_sdata <= enc_frame[NBITS-1];
                  o_busy  <= 1'b1;
                  o_sclk  <= 1'b0;
                  bit_cnt <= '0;
                  div_cnt <= '0;
                  state   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  if (!o_sclk) begin
                     o_sclk <= 1'b1;
                  end else if (bit_cnt == BIT_LAST) begin
                     o_sclk  <= 1'b0;
                     o_sdata <= 1'b0;
                     o_latch <= 1'b1;
                     state   <= ST_LATCH;
                  end else begin
                     o_sclk  <= 1'b0;
                     o_sdata <= frame[NBITS-1];
                     frame   <= frame << 1;
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            ST_LATCH: begin
               if (div_cnt == DIV_LAST) begin
                  o_latch <= 1'b0;
                  o_busy  <= 1'b0;
                  o_done  <= 1'b1;
                  state   <= ST_IDLE;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
